stage3_writeback_queued: RTL and testbench

Registered, handshaked successor to the combinational stage-3 (writeback / PC-update) block of the emulator CPU. It accepts one decoded stage-2 result per beat and commits RAM writes and the program counter. Output-device writes are queued in a parametrised FIFO so a slow device bus can drain them. Power-off (`mblock_s3`=7) drains the queue before the core reports powered off.

---
 rtl/stage3_writeback_queued.sv | 156 +++++++++++++++
 tb/tb_stage3_writeback_queued.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_writeback_queued.sv
// rtl/stage3_writeback_queued.sv - registered stage-3 writeback/PC-update with queued device writes
// Power-off waits in DRAIN until every queued device write has left the FIFO.
module stage3_writeback_queued #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int SRC_WIDTH      = 8,
  parameter int PC_STEP        = 4,
  parameter int RESET_PC       = 'h44,
  parameter int RAM_BASE       = 'h100,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [2:0]                        mblock_s3,
  input  logic [DATA_WIDTH-1:0]             vrw_value,
  input  logic [DATA_WIDTH-1:0]             vw_value,
  input  logic [SRC_WIDTH-1:0]              vrw_source,
  input  logic                              flag_last_zero,
  input  logic                              reset_button,
  output logic [ADDR_WIDTH-1:0]             ram_address,
  output logic [DATA_WIDTH-1:0]             ram_in,
  output logic                              ram_is_write,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SRC_WIDTH-1:0]              output_devices_address,
  output logic [DATA_WIDTH-1:0]             output_devices_value,
  output logic [ADDR_WIDTH-1:0]             pc,
  output logic                              is_powered_on,
  output logic                              execute_from_ram,
  output logic [$clog2(OUT_FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [SRC_WIDTH-1:0]  fifo_addr [OUT_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [OUT_FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  jump_taken;
  logic [ADDR_WIDTH-1:0] jump_target;

  assign fifo_full              = (count == CW'(OUT_FIFO_DEPTH));
  assign out_valid              = (count != '0);
  assign output_devices_address = fifo_addr[rd_ptr];
  assign output_devices_value   = fifo_data[rd_ptr];
  assign fifo_count             = count;
  assign jump_target            = vw_value[ADDR_WIDTH-1:0];

  // Ready looks at the opcode: only a device write is blocked by a full queue.
  always_comb begin
    in_ready = (state == ST_RUN) && !reset_button && !((mblock_s3 == 3'd2) && fifo_full);
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && (mblock_s3 == 3'd2);
  assign pop    = out_valid && out_ready;

  always_comb begin
    jump_taken = 1'b0;
    case (mblock_s3)
      3'd4:    jump_taken = 1'b1;
      3'd5:    jump_taken = flag_last_zero;
      3'd6:    jump_taken = !flag_last_zero;
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= vrw_source;
      fifo_data[wr_ptr] <= vw_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_OFF;
      pc               <= ADDR_WIDTH'(RESET_PC);
      is_powered_on    <= 1'b0;
      execute_from_ram <= 1'b0;
      ram_is_write     <= 1'b0;
      ram_address      <= '0;
      ram_in           <= '0;
    end else begin
      ram_is_write <= 1'b0;
      if (reset_button) begin
        // Queued device writes survive the button; they are already committed.
        state            <= ST_RUN;
        pc               <= ADDR_WIDTH'(RESET_PC);
        is_powered_on    <= 1'b1;
        execute_from_ram <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (accept) begin
              if (mblock_s3 == 3'd7) begin
                state <= ST_DRAIN;
              end else if (jump_taken) begin
                pc <= jump_target;
                if (jump_target >= ADDR_WIDTH'(RAM_BASE)) execute_from_ram <= 1'b1;
              end else begin
                pc <= pc + ADDR_WIDTH'(PC_STEP);
              end
              if (mblock_s3 == 3'd1) begin
                ram_address  <= ADDR_WIDTH'(vrw_source);
                ram_in       <= vw_value;
                ram_is_write <= 1'b1;
              end else if (mblock_s3 == 3'd3) begin
                ram_address  <= vrw_value[ADDR_WIDTH-1:0];
                ram_in       <= vw_value;
                ram_is_write <= 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (count == '0) begin
              state         <= ST_OFF;
              is_powered_on <= 1'b0;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage3_writeback_queued.sv
// tb/tb_stage3_writeback_queued.sv - directed and randomized bench with a queue-based reference model
module tb_stage3_writeback_queued;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mblock_s3;
  logic [31:0] vrw_value;
  logic [31:0] vw_value;
  logic [7:0]  vrw_source;
  logic        flag_last_zero;
  logic        reset_button;
  logic [15:0] ram_address;
  logic [31:0] ram_in;
  logic        ram_is_write;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  output_devices_address;
  logic [31:0] output_devices_value;
  logic [15:0] pc;
  logic        is_powered_on;
  logic        execute_from_ram;
  logic [2:0]  fifo_count;

  stage3_writeback_queued dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mblock_s3(mblock_s3), .vrw_value(vrw_value), .vw_value(vw_value),
    .vrw_source(vrw_source), .flag_last_zero(flag_last_zero),
    .reset_button(reset_button), .ram_address(ram_address), .ram_in(ram_in),
    .ram_is_write(ram_is_write), .out_valid(out_valid), .out_ready(out_ready),
    .output_devices_address(output_devices_address),
    .output_devices_value(output_devices_value), .pc(pc),
    .is_powered_on(is_powered_on), .execute_from_ram(execute_from_ram),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 = off, 1 = run, 2 = drain
  typedef struct { logic [7:0] a; logic [31:0] d; } ent_t;
  ent_t        m_q[$];
  int          m_st;
  logic [15:0] m_pc, m_ra, m_tgt;
  logic [31:0] m_ri;
  bit          m_on, m_efr, m_we, m_acc, m_pop, m_empty, m_take;
  bit          started = 0;
  logic [31:0] dut_seen[$];

  function automatic bit m_ready();
    return (m_st == 1) && !reset_button && !((mblock_s3 == 3'd2) && (m_q.size() == D));
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      started = 1;
      m_st = 0; m_pc = 16'h44; m_on = 0; m_efr = 0; m_we = 0; m_ra = 0; m_ri = 0;
      m_q.delete();
    end else if (started) begin
      m_acc   = in_valid && m_ready();
      m_empty = (m_q.size() == 0);
      m_pop   = !m_empty && out_ready;
      m_we    = 0;
      if (reset_button) begin
        m_st = 1; m_pc = 16'h44; m_on = 1; m_efr = 0;
      end else if (m_st == 2 && m_empty) begin
        m_st = 0; m_on = 0;
      end else if (m_acc) begin
        m_tgt  = vw_value[15:0];
        m_take = (mblock_s3 == 4) || (mblock_s3 == 5 && flag_last_zero) ||
                 (mblock_s3 == 6 && !flag_last_zero);
        if (mblock_s3 == 7) m_st = 2;
        else if (m_take) begin
          m_pc = m_tgt;
          if (m_tgt >= 16'h100) m_efr = 1;
        end else m_pc = m_pc + 16'd4;
        if (mblock_s3 == 1 || mblock_s3 == 3) begin
          m_we = 1;
          m_ra = (mblock_s3 == 1) ? {8'h00, vrw_source} : vrw_value[15:0];
          m_ri = vw_value;
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_acc && mblock_s3 == 2) m_q.push_back('{vrw_source, vw_value});
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("in_ready", in_ready, m_ready());
      chk("pc", pc, m_pc);
      chk("is_powered_on", is_powered_on, m_on);
      chk("execute_from_ram", execute_from_ram, m_efr);
      chk("ram_is_write", ram_is_write, m_we);
      chk("ram_address", ram_address, m_ra);
      chk("ram_in", ram_in, m_ri);
      chk("fifo_count", fifo_count, m_q.size());
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("dev_address", output_devices_address, m_q[0].a);
        chk("dev_value", output_devices_value, m_q[0].d);
      end
      if (out_valid && out_ready) dut_seen.push_back(output_devices_value);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [2:0] op, input logic [31:0] vrw, input logic [31:0] vw,
                      input logic [7:0] src, input logic flag);
    bit got;
    got = 0;
    in_valid = 1; mblock_s3 = op; vrw_value = vrw; vw_value = vw;
    vrw_source = src; flag_last_zero = flag;
    for (int i = 0; i < 64 && !got; i++) begin
      #1;
      got = in_ready;
      step();
    end
    in_valid = 0;
    if (!got) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_until_empty(input string nm);
    int n;
    n = 0;
    while (fifo_count != 0 && n < 40) begin step(); n++; end
    chk(nm, fifo_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; in_valid = 0; mblock_s3 = 0; vrw_value = 0; vw_value = 0;
    vrw_source = 0; flag_last_zero = 0; reset_button = 0; out_ready = 0;
    step(); step();
    reset = 0;
    chk("rst_pc", pc, 16'h44);
    chk("rst_on", is_powered_on, 0);
    chk("rst_efr", execute_from_ram, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_we", ram_is_write, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_in_ready", in_ready, 0);

    reset_button = 1; step(); reset_button = 0;
    chk("pwr_on", is_powered_on, 1);
    chk("pwr_pc", pc, 16'h44);
    chk("pwr_efr", execute_from_ram, 0);
    repeat (3) beat(0, 0, 0, 0, 0);
    chk("nop3_pc", pc, 16'h50);

    beat(1, 0, 99, 15, 0);
    chk("op1_addr", ram_address, 15);
    chk("op1_data", ram_in, 99);
    chk("op1_we", ram_is_write, 1);
    step();
    chk("op1_we_drop", ram_is_write, 0);
    beat(3, 97, 5, 0, 0);
    chk("op3_addr", ram_address, 97);

    beat(4, 0, 10, 0, 0);
    chk("jmp10_pc", pc, 10);
    beat(5, 0, 99, 0, 1);
    chk("jz_taken_pc", pc, 99);
    beat(4, 0, 10, 0, 0);
    beat(6, 0, 99, 0, 1);
    chk("jnz_not_taken_pc", pc, 14);
    chk("low_jump_efr", execute_from_ram, 0);
    beat(4, 0, 32'h200, 0, 0);
    chk("jmp200_pc", pc, 16'h200);
    chk("jmp200_efr", execute_from_ram, 1);
    beat(4, 0, 32'hFFFC, 0, 0);
    beat(0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 0);

    out_ready = 0;
    dut_seen.delete();
    for (int v = 1; v <= 4; v++) beat(2, 0, v, 8'h20 + 8'(v), 0);
    in_valid = 1; mblock_s3 = 2; vw_value = 5; vrw_source = 8'h25;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_count", fifo_count, 4);
    out_ready = 1;
    beat(2, 0, 5, 8'h25, 0);
    wait_until_empty("bp_drained");
    chk("bp_seen_n", dut_seen.size(), 5);
    for (int i = 0; i < 5 && i < dut_seen.size(); i++) chk("bp_order", dut_seen[i], i + 1);

    out_ready = 0;
    dut_seen.delete();
    beat(2, 0, 32'hA, 8'h31, 0);
    beat(2, 0, 32'hB, 8'h32, 0);
    beat(7, 0, 0, 0, 0);
    in_valid = 1; mblock_s3 = 0;
    step();
    chk("drain_on", is_powered_on, 1);
    chk("drain_in_ready", in_ready, 0);
    in_valid = 0;
    out_ready = 1;
    for (int n = 0; n < 20 && is_powered_on; n++) step();
    chk("drain_off", is_powered_on, 0);
    chk("drain_seen_n", dut_seen.size(), 2);
    if (dut_seen.size() == 2) begin
      chk("drain_first", dut_seen[0], 32'hA);
      chk("drain_second", dut_seen[1], 32'hB);
    end
    chk("drain_efr_kept", execute_from_ram, 1);

    reset_button = 1; step(); reset_button = 0;
    beat(4, 0, 32'h200, 0, 0);
    chk("rb_pre_efr", execute_from_ram, 1);
    reset_button = 1; in_valid = 1; mblock_s3 = 4; vw_value = 32'h300;
    #1;
    chk("rb_in_ready", in_ready, 0);
    step();
    reset_button = 0; in_valid = 0;
    chk("rb_pc", pc, 16'h44);
    chk("rb_efr", execute_from_ram, 0);

    out_ready = 0;
    beat(2, 0, 7, 1, 0);
    beat(2, 0, 8, 2, 0);
    chk("prereset_count", fifo_count, 2);
    reset = 1; step(); reset = 0;
    chk("reset_count", fifo_count, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_on", is_powered_on, 0);
    in_valid = 1; mblock_s3 = 0;
    #1;
    chk("reset_in_ready", in_ready, 0);
    in_valid = 0;

    reset_button = 1; step(); reset_button = 0;
    for (int i = 0; i < 800; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      reset_button   = ($urandom_range(0, 24) == 0);
      in_valid       = ($urandom_range(0, 3) != 0);
      mblock_s3      = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      vw_value       = $urandom;
      if ($urandom_range(0, 1) == 1) vw_value = $urandom_range(0, 32'h200);
      vrw_value      = $urandom;
      vrw_source     = 8'($urandom);
      flag_last_zero = 1'($urandom);
      out_ready      = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 0; reset_button = 0; in_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
